id_fwd_scoreboard: RTL and testbench
====================================

# id_fwd_scoreboard

Parametrised decode-stage hazard and bypass unit for the pipelined RV32I core. It replaces the fixed three-source, load-use-only interlock in the ID stage. It holds the IF→ID pipeline register with the valid/allow_in handshake and resolves rs1/rs2 operands from any number of bypass sources, ordered by priority. It stalls on late (load) producers and on long-latency producers (mul/div) tracked in a per-register scoreboard, and it counts stall cycles.

## Interface
- XLEN, 32, datapath width
- NREG, 32, architectural registers; AW = $clog2(NREG)
- NUM_FWD, 3, bypass sources; index 0 is the youngest (EX), which has the highest priority
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- in_valid  in  1  IF→ID valid
- in_pc, in_inst  in  XLEN, 32  fetched PC and instruction
- in_allow  out  1  ID can accept (id_allow_in)
- flush  in  1  branch cancel; kills the held instruction
- dec_rs1_en, dec_rs2_en, dec_rd_we, dec_long  in  1  decoder flags for the held instruction
- rf_rd1, rf_rd2  in  XLEN  register-file read data
- fwd_valid, fwd_we, fwd_late  in  NUM_FWD  per-source valid, write-enable, and data-not-ready (load in EX)
- fwd_reg  in  NUM_FWD*AW  destination register; source i is at [i*AW +: AW]
- fwd_data  in  NUM_FWD*XLEN  result data
- lc_valid  in  1  a long-latency op completes this cycle
- lc_reg  in  AW  destination of the completing op
- out_valid  out  1  id_to_ex_valid
- out_allow  in  1  ex_allow_in
- out_pc, out_inst  out  XLEN, 32  held PC and instruction
- out_rs1, out_rs2  out  XLEN  resolved operands
- sb_busy  out  NREG  scoreboard bitmap
- stall_cnt  out  32  saturating count of hazard-stall cycles

## Operation
- Register fields: rs1 = inst[19:15], rs2 = inst[24:20], rd = inst[11:7], each truncated to AW.
- Handshake: ready_go = !hazard. in_allow = !valid || (ready_go && out_allow). out_valid = valid && ready_go. fire = out_valid && out_allow.
- Valid register, in priority order: reset→0; flush→0; in_allow→in_valid. The held pc/inst load only when in_allow && in_valid.
- Match rule for source i: fwd_valid[i] && fwd_we[i] && fwd_reg[i] != 0 && fwd_reg[i] == rsX.
- Operand value: taken from the lowest-index matching source. If no source matches, the value is rf_rdX. Register 0 always reads rf_rdX and never causes a hazard.
- Late hazard: the first (highest-priority) match for rsX has fwd_late set. An older non-late match does not mask it.
- Scoreboard hazard: valid && rsX enabled && sb_busy[rsX].
- WAW hazard: valid && dec_rd_we && rd != 0 && sb_busy[rd].
- hazard = OR of all three terms, each gated by valid and the matching enable.
- Scoreboard set: fire && dec_long && dec_rd_we && rd != 0 sets sb_busy[rd].
- Scoreboard clear: lc_valid clears sb_busy[lc_reg].
- Same register set and cleared in one cycle: set wins. Bit 0 is never set.
- flush does not touch the scoreboard, because its entries belong to older, committed-path instructions.
- stall_cnt increments when valid && hazard && !flush, and saturates at 32'hFFFF_FFFF.

## Timing
- Reset values: valid 0, pc/inst 0, sb_busy 0, stall_cnt 0. Therefore out_valid = 0, and out_rs1/out_rs2 equal the rf inputs.
- Latency: an instruction accepted at edge N is presented at out_* during cycle N, i.e. after one register stage.
- All out_* signals are combinational from the held registers and the current-cycle bypass, scoreboard and rf inputs.
- A load-use stall lasts exactly one cycle when the load advances EX→MEM and clears fwd_late.
- A scoreboard stall lasts until the cycle after lc_valid for that register.
- flush together with in_valid: valid becomes 0 and the new instruction is dropped.
- Reset asserted mid-stall: all state clears on the next edge.

## Structure
- Shared defines.v gets: FWD source index constants, the stall-cause encoding, and the ID_TO_EX width update for the out_* bundle.
- One sub-module, fwd_mux: a parametrised priority bypass selector that returns value, hit, and late. It is instantiated twice, once for rs1 and once for rs2.

## Test plan
- Reset, then in_valid with inst 0x00500093 (addi x1,x0,5), rf_rd1 = 0 → next cycle out_valid = 1, out_rs1 = 0, stall_cnt = 0.
- Source 0 and source 2 both write x3: source 0 data 0xAAAA, source 2 data 0xBBBB, rs1 = x3 → out_rs1 = 0xAAAA.
- Source 0 is late for x5, held inst reads x5 → out_valid = 0 for 1 cycle and stall_cnt = 1; then fwd_late drops with MEM data 0x1234 → out_rs1 = 0x1234.
- Fire a long op writing x7 → sb_busy[7] = 1. The next inst reads x7 and stalls. Pulse lc_valid with lc_reg = 7 at cycle 4 → the bit clears and out_valid rises the following cycle.
- A long op to x9 fires in the same cycle as lc_valid with lc_reg = 9 → sb_busy[9] remains 1.
- flush while held inst is stalled and in_valid = 1 → valid = 0 next cycle, out_valid = 0, sb_busy unchanged.

Source files
------------

// File: rtl/id_fwd_scoreboard_pkg.sv
// Shared constants and helpers for the ID-stage hazard/bypass unit.
// Holds bypass source indices, the stall-cause encoding and the ID->EX bundle width.
package id_fwd_scoreboard_pkg;

    localparam int unsigned FWD_EX  = 0;
    localparam int unsigned FWD_MEM = 1;
    localparam int unsigned FWD_WB  = 2;

    // ID->EX bundle: valid, pc, inst, rs1 value, rs2 value (32-bit datapath)
    localparam int unsigned ID_TO_EX_W = 1 + 32 + 32 + 32 + 32;

    typedef enum logic [1:0] {
        STALL_NONE = 2'd0,
        STALL_LATE = 2'd1,
        STALL_SB   = 2'd2,
        STALL_WAW  = 2'd3
    } stall_cause_e;

    function automatic logic [4:0] inst_rs1(input logic [31:0] inst);
        return inst[19:15];
    endfunction

    function automatic logic [4:0] inst_rs2(input logic [31:0] inst);
        return inst[24:20];
    endfunction

    function automatic logic [4:0] inst_rd(input logic [31:0] inst);
        return inst[11:7];
    endfunction

    function automatic stall_cause_e stall_cause(input logic late_hz,
                                                 input logic sb_hz,
                                                 input logic waw_hz);
        if (late_hz)
            return STALL_LATE;
        else if (sb_hz)
            return STALL_SB;
        else if (waw_hz)
            return STALL_WAW;
        else
            return STALL_NONE;
    endfunction

endpackage

// File: rtl/id_fwd_scoreboard_fwd_mux.sv
// Priority bypass selector: the lowest-index matching source supplies the operand.
// Register 0 never matches, so it always reads the register file.
module fwd_mux
    import id_fwd_scoreboard_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned AW      = 5,
    parameter int unsigned NUM_FWD = 3
) (
    input  logic [AW-1:0]           rs,
    input  logic [XLEN-1:0]         rf_data,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD-1:0]      fwd_we,
    input  logic [NUM_FWD-1:0]      fwd_late,
    input  logic [NUM_FWD*AW-1:0]   fwd_reg,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    output logic [XLEN-1:0]         value,
    output logic                    hit,
    output logic                    late
);

    always_comb begin
        value = rf_data;
        hit   = 1'b0;
        late  = 1'b0;
        for (int unsigned i = 0; i < NUM_FWD; i++) begin
            if (!hit && fwd_valid[i] && fwd_we[i] &&
                fwd_reg[i*AW +: AW] != '0 && fwd_reg[i*AW +: AW] == rs) begin
                hit   = 1'b1;
                value = fwd_data[i*XLEN +: XLEN];
                late  = fwd_late[i];
            end
        end
    end

endmodule

// File: rtl/id_fwd_scoreboard.sv
// Decode-stage pipeline register with priority bypass, load-use and long-latency
// scoreboard interlocks, and a saturating stall-cycle counter.
module id_fwd_scoreboard
    import id_fwd_scoreboard_pkg::*;
#(
    parameter  int unsigned XLEN    = 32,
    parameter  int unsigned NREG    = 32,
    parameter  int unsigned NUM_FWD = 3,
    localparam int unsigned AW      = $clog2(NREG)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [XLEN-1:0]         in_pc,
    input  logic [31:0]             in_inst,
    output logic                    in_allow,
    input  logic                    flush,
    input  logic                    dec_rs1_en,
    input  logic                    dec_rs2_en,
    input  logic                    dec_rd_we,
    input  logic                    dec_long,
    input  logic [XLEN-1:0]         rf_rd1,
    input  logic [XLEN-1:0]         rf_rd2,
    input  logic [NUM_FWD-1:0]      fwd_valid,
    input  logic [NUM_FWD-1:0]      fwd_we,
    input  logic [NUM_FWD-1:0]      fwd_late,
    input  logic [NUM_FWD*AW-1:0]   fwd_reg,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    input  logic                    lc_valid,
    input  logic [AW-1:0]           lc_reg,
    output logic                    out_valid,
    input  logic                    out_allow,
    output logic [XLEN-1:0]         out_pc,
    output logic [31:0]             out_inst,
    output logic [XLEN-1:0]         out_rs1,
    output logic [XLEN-1:0]         out_rs2,
    output logic [NREG-1:0]         sb_busy,
    output logic [31:0]             stall_cnt
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     inst_q;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [31:0]     stall_q;

    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [AW-1:0]   rd;
    logic            rs1_hit;
    logic            rs1_late;
    logic            rs2_hit;
    logic            rs2_late;
    logic            late_hz;
    logic            sb_hz;
    logic            waw_hz;
    logic            hazard;
    logic            ready_go;
    logic            fire;
    logic            sb_set;
    stall_cause_e    cause;

    assign rs1 = AW'(inst_rs1(inst_q));
    assign rs2 = AW'(inst_rs2(inst_q));
    assign rd  = AW'(inst_rd(inst_q));

    fwd_mux #(
        .XLEN    (XLEN),
        .AW      (AW),
        .NUM_FWD (NUM_FWD)
    ) u_mux_rs1 (
        .rs        (rs1),
        .rf_data   (rf_rd1),
        .fwd_valid (fwd_valid),
        .fwd_we    (fwd_we),
        .fwd_late  (fwd_late),
        .fwd_reg   (fwd_reg),
        .fwd_data  (fwd_data),
        .value     (out_rs1),
        .hit       (rs1_hit),
        .late      (rs1_late)
    );

    fwd_mux #(
        .XLEN    (XLEN),
        .AW      (AW),
        .NUM_FWD (NUM_FWD)
    ) u_mux_rs2 (
        .rs        (rs2),
        .rf_data   (rf_rd2),
        .fwd_valid (fwd_valid),
        .fwd_we    (fwd_we),
        .fwd_late  (fwd_late),
        .fwd_reg   (fwd_reg),
        .fwd_data  (fwd_data),
        .value     (out_rs2),
        .hit       (rs2_hit),
        .late      (rs2_late)
    );

    // Only the highest-priority match decides lateness; older matches cannot mask it.
    assign late_hz = valid_q && ((dec_rs1_en && rs1_hit && rs1_late) ||
                                 (dec_rs2_en && rs2_hit && rs2_late));
    assign sb_hz   = valid_q && ((dec_rs1_en && busy_q[rs1]) ||
                                 (dec_rs2_en && busy_q[rs2]));
    assign waw_hz  = valid_q && dec_rd_we && (rd != '0) && busy_q[rd];

    assign cause     = stall_cause(late_hz, sb_hz, waw_hz);
    assign hazard    = (cause != STALL_NONE);
    assign ready_go  = !hazard;
    assign in_allow  = !valid_q || (ready_go && out_allow);
    assign out_valid = valid_q && ready_go;
    assign fire      = out_valid && out_allow;
    assign sb_set    = fire && dec_long && dec_rd_we && (rd != '0);

    assign out_pc    = pc_q;
    assign out_inst  = inst_q;
    assign sb_busy   = busy_q;
    assign stall_cnt = stall_q;

    // Clear is applied before set so an issue to the completing register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (lc_valid)
            busy_d[lc_reg] = 1'b0;
        if (sb_set)
            busy_d[rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= '0;
            busy_q  <= '0;
            stall_q <= '0;
        end else begin
            if (flush)
                valid_q <= 1'b0;
            else if (in_allow)
                valid_q <= in_valid;

            if (in_allow && in_valid) begin
                pc_q   <= in_pc;
                inst_q <= in_inst;
            end

            busy_q <= busy_d;

            if (hazard && !flush && stall_q != '1)
                stall_q <= stall_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_id_fwd_scoreboard.sv
// Scoreboard bench for id_fwd_scoreboard: directed scenarios then random traffic,
// checked against a behavioural model of the ID stage.
module tb_id_fwd_scoreboard;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NF   = 3;
    localparam int AW   = 5;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic [XLEN-1:0]    in_pc;
    logic [31:0]        in_inst;
    logic               in_allow;
    logic               flush;
    logic               dec_rs1_en, dec_rs2_en, dec_rd_we, dec_long;
    logic [XLEN-1:0]    rf_rd1, rf_rd2;
    logic [NF-1:0]      fwd_valid, fwd_we, fwd_late;
    logic [NF*AW-1:0]   fwd_reg;
    logic [NF*XLEN-1:0] fwd_data;
    logic               lc_valid;
    logic [AW-1:0]      lc_reg;
    logic               out_valid;
    logic               out_allow;
    logic [XLEN-1:0]    out_pc;
    logic [31:0]        out_inst;
    logic [XLEN-1:0]    out_rs1, out_rs2;
    logic [NREG-1:0]    sb_busy;
    logic [31:0]        stall_cnt;

    always #5 clk = ~clk;

    id_fwd_scoreboard #(
        .XLEN    (XLEN),
        .NREG    (NREG),
        .NUM_FWD (NF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_pc      (in_pc),
        .in_inst    (in_inst),
        .in_allow   (in_allow),
        .flush      (flush),
        .dec_rs1_en (dec_rs1_en),
        .dec_rs2_en (dec_rs2_en),
        .dec_rd_we  (dec_rd_we),
        .dec_long   (dec_long),
        .rf_rd1     (rf_rd1),
        .rf_rd2     (rf_rd2),
        .fwd_valid  (fwd_valid),
        .fwd_we     (fwd_we),
        .fwd_late   (fwd_late),
        .fwd_reg    (fwd_reg),
        .fwd_data   (fwd_data),
        .lc_valid   (lc_valid),
        .lc_reg     (lc_reg),
        .out_valid  (out_valid),
        .out_allow  (out_allow),
        .out_pc     (out_pc),
        .out_inst   (out_inst),
        .out_rs1    (out_rs1),
        .out_rs2    (out_rs2),
        .sb_busy    (sb_busy),
        .stall_cnt  (stall_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } txn_t;

    txn_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    // reference model state
    bit          m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    bit          m_busy[NREG];
    longint      m_stall;

    // per-cycle expectations
    bit exp_hazard, exp_out_valid, exp_in_allow, exp_fire;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] busy_vec();
        logic [31:0] v = '0;
        for (int r = 0; r < NREG; r++) v[r] = m_busy[r];
        return v;
    endfunction

    // Youngest source writing a nonzero register wins; otherwise register-file data.
    function automatic void resolve(input int r, input logic [31:0] rf,
                                    output logic [31:0] v, output bit is_late);
        v = rf;
        is_late = 1'b0;
        if (r == 0) return;
        for (int i = 0; i < NF; i++) begin
            if (fwd_valid[i] && fwd_we[i] && int'(fwd_reg[i*AW +: AW]) == r) begin
                v = fwd_data[i*XLEN +: XLEN];
                is_late = fwd_late[i];
                return;
            end
        end
    endfunction

    function automatic void model_eval();
        int r1, r2, rdn;
        logic [31:0] v1, v2;
        bit l1, l2, need;
        r1  = int'(m_inst[19:15]);
        r2  = int'(m_inst[24:20]);
        rdn = int'(m_inst[11:7]);
        resolve(r1, rf_rd1, v1, l1);
        resolve(r2, rf_rd2, v2, l2);
        need = (dec_rs1_en && (l1 || m_busy[r1])) ||
               (dec_rs2_en && (l2 || m_busy[r2])) ||
               (dec_rd_we && rdn != 0 && m_busy[rdn]);
        exp_hazard    = m_valid && need;
        exp_out_valid = m_valid && !need;
        exp_in_allow  = !m_valid || (!need && out_allow);
        exp_fire      = exp_out_valid && out_allow;
        if (exp_fire) exp_q.push_back('{pc: m_pc, inst: m_inst, rs1: v1, rs2: v2});
    endfunction

    function automatic void model_update();
        int rdn;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_pc    = '0;
            m_inst  = '0;
            for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
            m_stall = 0;
            return;
        end
        rdn = int'(m_inst[11:7]);
        if (exp_hazard && !flush && m_stall < 64'h0000_0000_FFFF_FFFF) m_stall++;
        if (lc_valid) m_busy[int'(lc_reg)] = 1'b0;
        if (exp_fire && dec_long && dec_rd_we && rdn != 0) m_busy[rdn] = 1'b1;
        if (exp_in_allow && in_valid) begin
            m_pc   = in_pc;
            m_inst = in_inst;
        end
        if (flush) m_valid = 1'b0;
        else if (exp_in_allow) m_valid = in_valid;
    endfunction

    task automatic idle();
        rst_n = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; flush = 1'b0;
        dec_rs1_en = 1'b0; dec_rs2_en = 1'b0; dec_rd_we = 1'b0; dec_long = 1'b0;
        rf_rd1 = '0; rf_rd2 = '0; fwd_valid = '0; fwd_we = '0; fwd_late = '0;
        fwd_reg = '0; fwd_data = '0; lc_valid = 1'b0; lc_reg = '0; out_allow = 1'b1;
    endtask

    task automatic randomize_inputs();
        logic [4:0] a, b, d;
        a = 5'($urandom_range(0, 7));
        b = 5'($urandom_range(0, 7));
        d = 5'($urandom_range(0, 7));
        rst_n      = ($urandom_range(0, 99) != 0);
        in_valid   = 1'($urandom_range(0, 1));
        in_pc      = $urandom;
        in_inst    = {7'($urandom), b, a, 3'($urandom), d, 7'($urandom)};
        flush      = ($urandom_range(0, 19) == 0);
        dec_rs1_en = 1'($urandom_range(0, 1));
        dec_rs2_en = 1'($urandom_range(0, 1));
        dec_rd_we  = 1'($urandom_range(0, 1));
        dec_long   = ($urandom_range(0, 3) == 0);
        rf_rd1     = $urandom;
        rf_rd2     = $urandom;
        for (int i = 0; i < NF; i++) begin
            fwd_valid[i]             = 1'($urandom_range(0, 1));
            fwd_we[i]                = 1'($urandom_range(0, 1));
            fwd_late[i]              = ($urandom_range(0, 4) == 0);
            fwd_reg[i*AW +: AW]      = 5'($urandom_range(0, 7));
            fwd_data[i*XLEN +: XLEN] = $urandom;
        end
        lc_valid  = ($urandom_range(0, 2) == 0);
        lc_reg    = 5'($urandom_range(0, 7));
        out_allow = ($urandom_range(0, 3) != 0);
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic tick();
        settle();
        advance();
    endtask

    // monitor: per-cycle state checks and in-order transaction checks on every fire
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                check("out_valid", 64'(out_valid), 64'(exp_out_valid));
                check("in_allow", 64'(in_allow), 64'(exp_in_allow));
                check("sb_busy", 64'(sb_busy), 64'(busy_vec()));
                check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
                if (out_valid && out_allow) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL txn_unexpected: got pc %0h with no expected transaction", out_pc);
                    end else begin
                        t = exp_q.pop_front();
                        check("txn_pc", 64'(out_pc), 64'(t.pc));
                        check("txn_inst", 64'(out_inst), 64'(t.inst));
                        check("txn_rs1", 64'(out_rs1), 64'(t.rs1));
                        check("txn_rs2", 64'(out_rs2), 64'(t.rs2));
                    end
                end
            end
        end
    end

    initial begin
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        tick();
        tick();
        mon_en = 1'b1;

        // reset state
        idle();
        rf_rd1 = 32'h5555_1234;
        settle();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        check("rst_sb_busy", 64'(sb_busy), 64'd0);
        check("rst_out_rs1", 64'(out_rs1), 64'h5555_1234);
        advance();

        // addi x1,x0,5 accepted and presented next cycle
        idle();
        in_valid = 1'b1; in_pc = 32'h100; in_inst = 32'h0050_0093;
        tick();
        idle();
        dec_rs1_en = 1'b1; dec_rd_we = 1'b1;
        settle();
        check("addi_out_valid", 64'(out_valid), 64'd1);
        check("addi_out_rs1", 64'(out_rs1), 64'd0);
        check("addi_stall_cnt", 64'(stall_cnt), 64'd0);
        advance();

        // bypass priority: source 0 beats source 2 for x3
        idle();
        in_valid = 1'b1; in_pc = 32'h104; in_inst = 32'h0001_8213;
        tick();
        idle();
        dec_rs1_en = 1'b1;
        fwd_valid = 3'b101; fwd_we = 3'b101;
        fwd_reg = {5'd3, 5'd0, 5'd3};
        fwd_data = {32'h0000_BBBB, 32'h0000_0000, 32'h0000_AAAA};
        settle();
        check("prio_out_rs1", 64'(out_rs1), 64'h0000_AAAA);
        advance();

        // load-use: one-cycle stall, then MEM forwards the data
        idle();
        in_valid = 1'b1; in_pc = 32'h108; in_inst = 32'h0002_8313;
        tick();
        idle();
        dec_rs1_en = 1'b1;
        fwd_valid = 3'b001; fwd_we = 3'b001; fwd_late = 3'b001;
        fwd_reg = {5'd0, 5'd0, 5'd5};
        settle();
        check("load_stall_valid", 64'(out_valid), 64'd0);
        advance();
        idle();
        dec_rs1_en = 1'b1;
        fwd_valid = 3'b010; fwd_we = 3'b010;
        fwd_reg = {5'd0, 5'd5, 5'd0};
        fwd_data = {32'h0, 32'h0000_1234, 32'h0};
        settle();
        check("load_stall_cnt", 64'(stall_cnt), 64'd1);
        check("load_out_valid", 64'(out_valid), 64'd1);
        check("load_out_rs1", 64'(out_rs1), 64'h0000_1234);
        advance();

        // long op to x7, dependent instruction waits for lc_valid
        idle();
        in_valid = 1'b1; in_pc = 32'h10C; in_inst = 32'h0000_03B3;
        tick();
        idle();
        dec_long = 1'b1; dec_rd_we = 1'b1;
        in_valid = 1'b1; in_pc = 32'h110; in_inst = 32'h0003_8413;
        settle();
        check("long_fire", 64'(out_valid), 64'd1);
        advance();
        for (int c = 0; c < 3; c++) begin
            idle();
            dec_rs1_en = 1'b1; dec_rd_we = 1'b1;
            lc_valid = (c == 2); lc_reg = 5'd7;
            settle();
            check("sb7_busy", 64'(sb_busy[7]), 64'd1);
            check("sb7_stall", 64'(out_valid), 64'd0);
            advance();
        end
        idle();
        dec_rs1_en = 1'b1; dec_rd_we = 1'b1;
        settle();
        check("sb7_cleared", 64'(sb_busy[7]), 64'd0);
        check("sb7_release", 64'(out_valid), 64'd1);
        advance();

        // set and clear of x9 in the same cycle: set wins
        idle();
        in_valid = 1'b1; in_pc = 32'h114; in_inst = 32'h0000_04B3;
        tick();
        idle();
        dec_long = 1'b1; dec_rd_we = 1'b1; lc_valid = 1'b1; lc_reg = 5'd9;
        tick();
        idle();
        settle();
        check("sb9_set_wins", 64'(sb_busy[9]), 64'd1);
        advance();

        // flush a stalled instruction while a new one arrives
        idle();
        in_valid = 1'b1; in_pc = 32'h118; in_inst = 32'h0004_8513;
        tick();
        idle();
        dec_rs1_en = 1'b1;
        settle();
        check("flush_pre_stall", 64'(out_valid), 64'd0);
        advance();
        idle();
        dec_rs1_en = 1'b1; flush = 1'b1;
        in_valid = 1'b1; in_pc = 32'h11C; in_inst = 32'h0000_0013;
        tick();
        idle();
        settle();
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_sb_busy", 64'(sb_busy), 64'h0000_0200);
        advance();
        idle();
        lc_valid = 1'b1; lc_reg = 5'd9;
        tick();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            randomize_inputs();
            tick();
        end

        // drain
        for (int n = 0; n < 4; n++) begin
            idle();
            tick();
        end
        mon_en = 1'b0;
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
